// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop, with valid/ready on both sides.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] dsr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] diff_next;

    // Full-subtractor cell; dsr collects the upper bits so diff only updates on completion.
    always_comb begin
        d         = sa[0] ^ sb[0] ^ br;
        br_next   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        diff_next = {d, dsr};
    end

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            dsr       <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    dsr <= diff_next[WIDTH-1:1];
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // br here is the borrow into the MSB stage
                        diff      <= diff_next;
                        bout      <= br_next;
                        ovf       <= br ^ br_next;
                        zero      <= (diff_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_full_subtractor.md
# serial_full_subtractor

Bit-serial N-bit subtractor computing `a - b - bin` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop. It is the inverse arithmetic counterpart to the team's full-adder cells. It provides an area-minimal datapath for the arithmetic challenge blocks, with valid/ready handshakes on both sides so it drops into the existing pipelines.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits (legal values 2 to 32).

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `in_valid`, in, 1: operands and `bin` are valid.
- `in_ready`, out, 1: block can accept an operation.
- `a`, in, WIDTH: minuend.
- `b`, in, WIDTH: subtrahend.
- `bin`, in, 1: borrow-in.
- `out_valid`, out, 1: result is valid.
- `out_ready`, in, 1: consumer accepts the result.
- `diff`, out, WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout`, out, 1: borrow-out. 1 when unsigned `a < b + bin`.
- `ovf`, out, 1: two's-complement signed overflow.
- `zero`, out, 1: `diff == 0`.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready = 1`.
  - On an edge with `in_valid & in_ready`: load shift registers `sa <= a`, `sb <= b`, borrow flop `br <= bin`, bit counter `cnt <= 0`; go to RUN.
- RUN (exactly WIDTH cycles), one full-subtractor step per edge:
  - `d = sa[0] ^ sb[0] ^ br`
  - `br <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`
  - Shift `sa` and `sb` right by one.
  - Shift `d` into the MSB of the `diff` shift register (shifting right).
  - `cnt <= cnt + 1`.
  - On the step where `cnt == WIDTH-1`:
    - Capture the borrow into the MSB stage (current `br`) as `bmsb`.
    - Go to DONE.
- DONE:
  - `out_valid = 1`.
  - Outputs:
    - `bout = br`.
    - `ovf = bmsb ^ br`.
    - `zero = (diff == 0)`.
  - All of these are registered and stable while `out_valid` is high.
  - On an edge with `out_valid & out_ready`: go to IDLE.
  - `diff`, `bout`, `ovf` and `zero` hold their values after that edge until the next DONE.
- `in_ready = 0` in RUN and DONE. `in_valid` is ignored there.
- Operands are sampled only on the accept edge; later changes on `a`, `b` or `bin` have no effect.
- `cnt` width is `clog2(WIDTH+1)` bits; it never wraps within an operation.

## Timing

- Reset:
  - While `rst` is high, `in_ready` is forced to 0 and the inputs are ignored.
  - After the first reset edge: state is IDLE; `out_valid`, `diff`, `bout`, `ovf`, `zero`, `sa`, `sb`, `br`, `cnt` are all 0.
  - `in_ready` is 1 in the first cycle after `rst` deasserts.
- Reset mid-operation (RUN or DONE): the operation is aborted on that edge, no result is ever presented, and the block returns to IDLE.
- Latency: with the accept edge at E0, `out_valid` rises after edge E0+WIDTH.
- Throughput: with `out_ready` held high, the result is consumed at edge E0+WIDTH+1, IDLE lasts one cycle, and the next accept is at E0+WIDTH+2. Sustained rate is one operation per WIDTH+2 cycles.
- Backpressure: DONE holds indefinitely while `out_ready = 0`; outputs do not change.
- No combinational path exists from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan

All scenarios use WIDTH=8.
- Basic subtract: `a=0x05`, `b=0x03`, `bin=0` accepted at E0 -> `out_valid` high after E0+8; `diff=0x02`, `bout=0`, `ovf=0`, `zero=0`.
- Unsigned underflow: `0x03 - 0x05` with `bin=0` -> `diff=0xFE`, `bout=1`, `ovf=0`. Separately, `0x80 - 0x01` -> `diff=0x7F`, `bout=0`, `ovf=1`.
- Borrow-in and zero: `0x10 - 0x0F` with `bin=1` -> `diff=0x00`, `zero=1`, `bout=0`. Separately, `0x00 - 0x00` with `bin=1` -> `diff=0xFF`, `bout=1`.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE and pulse `in_valid` with new operands -> outputs remain constant, `in_ready` stays 0, and the new operands are not consumed.
- Reset abort: assert `rst` for one edge at the 3rd RUN cycle -> `out_valid` never rises for that operation, `in_ready=1` the next cycle, and a new operation `0x20 - 0x01` yields `0x1F`.
- Back-to-back: `in_valid` and `out_ready` held high with a stream of 4 random operand pairs -> accepts spaced exactly 10 cycles apart, and all results match the 8-bit reference model.
